// File: rtl/div_pkg.sv
// Shared definitions for the sequential non-restoring divider.
package div_pkg;
  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;
endpackage

// File: rtl/addsub_nbit.sv
// N-bit adder/subtractor: y = a + b (sel=0) or a - b (sel=1), two's complement.
module addsub_nbit #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sel,
  output logic [N-1:0] y
);
  assign y = a + (b ^ {N{sel}}) + {{(N-1){1'b0}}, sel};
endmodule

// File: rtl/div_nr_seq.sv
// Unsigned sequential non-restoring divider, one quotient bit per cycle,
// with a single shared add/subtract path used by both RUN and FIX.
module div_nr_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH:0]   pr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   as_a, as_b, as_y;
  logic             as_sel;

  // RUN: shift {pr,q} left and subtract/add by the sign of pr.
  // FIX: restore a negative remainder by adding the divisor once.
  always_comb begin
    as_b = {1'b0, d};
    if (state == FIX) begin
      as_a   = pr;
      as_sel = 1'b0;
    end else begin
      as_a   = {pr[WIDTH-1:0], q[WIDTH-1]};
      as_sel = ~pr[WIDTH];
    end
  end

  addsub_nbit #(.N(WIDTH + 1)) u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sel (as_sel),
    .y   (as_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && divisor != '0) state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr          <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end else begin
              pr  <= '0;
              q   <= dividend;
              d   <= divisor;
              cnt <= '0;
            end
          end
        end
        RUN: begin
          pr  <= as_y;
          q   <= {q[WIDTH-2:0], ~as_y[WIDTH]};
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          quotient    <= q;
          remainder   <= pr[WIDTH] ? as_y[WIDTH-1:0] : pr[WIDTH-1:0];
          div_by_zero <= 1'b0;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_nr_seq.sv
// Scoreboard bench for div_nr_seq: directed cases plus a randomized sweep
// against a plain-arithmetic reference model.
module tb_div_nr_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  div_nr_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;

  typedef struct {
    int q;
    int r;
    int z;
    int at;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t ref_div(int a, int b, int at);
    exp_t e;
    e.at = at;
    if (b == 0) begin
      e.q = (1 << W) - 1;
      e.r = a;
      e.z = 1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 0;
    end
    return e;
  endfunction

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: q=%0d r=%0d z=%0d with nothing expected", quotient, remainder, div_by_zero);
      end else begin
        e = sb.pop_front();
        if (int'(quotient) != e.q || int'(remainder) != e.r ||
            int'(div_by_zero) != e.z || ecount != e.at) begin
          n_fail++;
          $display("FAIL result: got q=%0d r=%0d z=%0d at=%0d expected q=%0d r=%0d z=%0d at=%0d",
                   quotient, remainder, div_by_zero, ecount, e.q, e.r, e.z, e.at);
        end
      end
    end
  end

  // Issue one operation (called between edges, DUT idle or in its done cycle)
  // and return at the negedge where done is seen.
  task automatic run_op(int a, int b, bit noise);
    exp_t e;
    e = ref_div(a, b, ecount + 1 + ((b != 0) ? W + 1 : 0));
    sb.push_back(e);
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (noise) begin
      dividend = W'($urandom);
      divisor  = W'($urandom);
    end
    @(negedge clk);
    check("busy_after_accept", int'(busy), (b != 0) ? 1 : 0);
    for (int i = 0; i < W + 4 && !done; i++) begin
      if (noise) begin
        start    = 1'($urandom_range(0, 1));
        dividend = (i % 2 == 0) ? W'(10) : W'($urandom);
        divisor  = (i % 2 == 0) ? W'(2)  : W'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: no done for %0d/%0d", a, b);
    end
  endtask

  function automatic int pick(int special);
    int s;
    s = int'($urandom_range(0, 9));
    if (s == 0) return special;
    if (s == 1) return 1;
    if (s == 2) return 255;
    return int'($urandom_range(0, 255));
  endfunction

  initial begin
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_q", int'(quotient), 0);
    check("rst_r", int'(remainder), 0);
    check("rst_z", int'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(100, 7, 0);
    repeat (3) @(negedge clk);
    check("hold_q", int'(quotient), 14);
    check("hold_r", int'(remainder), 2);
    check("hold_done_low", int'(done), 0);

    run_op(255, 1, 0);
    run_op(5, 9, 0);
    @(negedge clk);
    run_op(200, 0, 0);
    check("zero_busy", int'(busy), 0);
    run_op(9, 3, 0);
    @(negedge clk);
    run_op(250, 16, 1);
    run_op(0, 255, 0);

    // Abort mid-operation with reset.
    @(negedge clk);
    start = 1'b1; dividend = 8'd77; divisor = 8'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_q", int'(quotient), 0);
    check("abort_r", int'(remainder), 0);
    check("abort_z", int'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(77, 5, 0);

    for (int n = 0; n < 5000; n++) begin
      int a, b;
      a = pick(0);
      b = pick(0);
      run_op(a, b, ($urandom_range(0, 3) == 0));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
